branch_redirect: RTL and testbench
==================================

# branch_redirect

Execute-stage branch resolution and redirect generator: the producer side of the fetch PC-select interface. It evaluates conditional branches, JAL and JALR against operands from EX and computes the target. It registers a redirect (`branch_taken`, `pc_branch`) and holds it toward fetch until fetch accepts it. While the redirect is outstanding it flushes the wrong-path front end. Static predict-not-taken: fetch runs on `pcplus4` until redirected.

## Interface
- No parameters; all datapath widths are `u64` (64 bits) from `common`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: EX holds a valid instruction this cycle.
- `ex_kind` in 2: 0 = none, 1 = conditional branch, 2 = JAL, 3 = JALR.
- `ex_funct3` in 3: branch condition (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; others never taken).
- `ex_pc` in 64: PC of the EX instruction.
- `ex_imm` in 64: sign-extended immediate.
- `ex_rs1`, `ex_rs2` in 64 each: forwarded operand values.
- `fetch_accept` in 1: fetch consumes `pc_selected` this cycle.
- `branch_taken` out 1: redirect request to pcselect.
- `pc_branch` out 64: redirect target.
- `flush_front` out 1: kill IF, ID and EX valid bits.
- `link_value` out 64: combinational `ex_pc + 4`, the JAL/JALR rd writeback value.
- `misalign_exc` out 1: one-cycle pulse, taken target not 4-byte aligned.
- `misalign_addr` out 64: the offending target; valid while `misalign_exc` is high.
- `redirect_count` out 64: number of redirects accepted by fetch.

## Operation
- FSM has two states, IDLE and PENDING. Reset puts it in IDLE, all outputs 0, `redirect_count` = 0.
- **Resolution.** A resolution occurs in IDLE when `ex_valid` is high and `ex_kind` is not 0.
  - Taken: kind 2 or 3 always; kind 1 when the `ex_funct3` condition holds. BLT/BGE compare signed, BLTU/BGEU compare unsigned.
- **Target.**
  - Kinds 1 and 2: `ex_pc + ex_imm`.
  - Kind 3: `(ex_rs1 + ex_imm) & ~64'h1`.
  - All additions are 64-bit modulo 2^64; wrap-around is legal and not flagged.
- **Taken, target bit 1 = 0.** Latch `pc_branch` = target and go to PENDING.
- **Taken, target bit 1 = 1.** Stay in IDLE. Pulse `misalign_exc` for one cycle with `misalign_addr` = target. No redirect.
- **Not taken.** No action; fetch continues on `pcplus4`.
- **PENDING.**
  - `branch_taken` = `flush_front` = 1 and `pc_branch` is held stable.
  - All `ex_valid` input is ignored; EX contents are wrong-path.
  - On `fetch_accept` = 1: return to IDLE next cycle and increment `redirect_count` by 1, with 64-bit wrap.
- **Accept and ex_valid in the same cycle.** The EX instruction is wrong-path and is ignored; no new resolution that cycle.
- **reset** has priority over everything, including mid-PENDING: the pending redirect is dropped and the counter cleared.

## Timing
- Resolution in cycle N gives `branch_taken`, `pc_branch` and `flush_front` high from cycle N+1, i.e. one cycle of latency.
- Redirect outputs stay high through the cycle in which `fetch_accept` = 1, and are 0 the cycle after.
- A redirect accepted in the same cycle it first appears gives a one-cycle pulse.
- `misalign_exc` is registered: resolution in cycle N gives the pulse in cycle N+1 only.
- The earliest next resolution is the cycle after return to IDLE. Back-to-back redirects are therefore at least two cycles apart.
- `link_value` is combinational, with no latency.
- `redirect_count` updates on the edge that ends the accepting cycle.

## Test plan
1. Reset held for 2 cycles, then released → all outputs 0 and `redirect_count` = 0; `ex_valid` = 0 keeps the block in IDLE.
2. BEQ at `ex_pc` = 0x8000_0000, `ex_imm` = 0x40, rs1 = rs2 = 5, `fetch_accept` = 1 → in N+1, `branch_taken` = 1 and `pc_branch` = 0x8000_0040; in N+2 it is 0 and `redirect_count` = 1. The same BEQ with rs2 = 6 produces no redirect.
3. BLT vs BLTU with rs1 = 0xFFFF_FFFF_FFFF_FFFF and rs2 = 1 → BLT taken, BLTU not taken.
4. JALR with rs1 = 0x8000_1003 and imm = 0 → `pc_branch` = 0x8000_1002 is misaligned, so `misalign_exc` pulses once with `misalign_addr` = 0x8000_1002 and `branch_taken` stays 0. JALR with rs1 = 0x8000_1001 → redirect to 0x8000_1000.
5. JAL taken with `fetch_accept` low for 3 cycles → `branch_taken` and `flush_front` high for 4 cycles with `pc_branch` stable. A taken BNE presented on `ex_valid` during PENDING is ignored. `redirect_count` increments exactly once.
6. `reset` asserted while PENDING → next cycle all outputs 0 and IDLE; the redirect is not replayed.

Source files
------------

// File: rtl/branch_redirect_if.sv
// Bundle between EX-stage branch resolution and the fetch PC-select logic.
// The master side is the redirect producer (branch_redirect); the slave side
// is the pipeline/fetch environment that feeds EX operands and accepts redirects.
interface branch_redirect_if;
    logic        ex_valid;
    logic [1:0]  ex_kind;
    logic [2:0]  ex_funct3;
    logic [63:0] ex_pc;
    logic [63:0] ex_imm;
    logic [63:0] ex_rs1;
    logic [63:0] ex_rs2;
    logic        fetch_accept;
    logic        branch_taken;
    logic [63:0] pc_branch;
    logic        flush_front;
    logic [63:0] link_value;
    logic        misalign_exc;
    logic [63:0] misalign_addr;
    logic [63:0] redirect_count;

    modport master (
        input  ex_valid, ex_kind, ex_funct3, ex_pc, ex_imm, ex_rs1, ex_rs2,
        input  fetch_accept,
        output branch_taken, pc_branch, flush_front, link_value,
        output misalign_exc, misalign_addr, redirect_count
    );

    modport slave (
        output ex_valid, ex_kind, ex_funct3, ex_pc, ex_imm, ex_rs1, ex_rs2,
        output fetch_accept,
        input  branch_taken, pc_branch, flush_front, link_value,
        input  misalign_exc, misalign_addr, redirect_count
    );
endinterface

// File: rtl/branch_redirect.sv
// Execute-stage branch resolution and redirect generator.
// Resolves conditional branches, JAL and JALR, registers a redirect toward
// fetch and holds it (flushing the wrong-path front end) until fetch accepts.
// Static predict-not-taken: only taken control flow produces a redirect.
module branch_redirect (
    input  logic              clk,
    input  logic              reset,
    branch_redirect_if.master bus
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    localparam logic [1:0] KIND_NONE   = 2'd0;
    localparam logic [1:0] KIND_BRANCH = 2'd1;
    localparam logic [1:0] KIND_JAL    = 2'd2;
    localparam logic [1:0] KIND_JALR   = 2'd3;

    logic [0:0]  state;
    logic [63:0] pc_branch_q;
    logic        misalign_q;
    logic [63:0] misalign_addr_q;
    logic [63:0] count_q;

    logic        cond_true;
    logic [63:0] target;
    logic        resolve;
    logic        taken;

    // Evaluate the branch condition and the control-flow target for the EX instruction
    always_comb begin
        cond_true = 1'b0;
        target    = bus.ex_pc + bus.ex_imm;
        case (bus.ex_funct3)
            3'b000:  cond_true = (bus.ex_rs1 == bus.ex_rs2);
            3'b001:  cond_true = (bus.ex_rs1 != bus.ex_rs2);
            3'b100:  cond_true = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101:  cond_true = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110:  cond_true = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111:  cond_true = (bus.ex_rs1 >= bus.ex_rs2);
            default: cond_true = 1'b0;
        endcase
        if (bus.ex_kind == KIND_JALR) begin
            target = (bus.ex_rs1 + bus.ex_imm) & ~64'h1;
        end
    end

    // A resolution only happens in IDLE; in PENDING the EX contents are wrong-path
    always_comb begin
        resolve = (state == IDLE) && bus.ex_valid && (bus.ex_kind != KIND_NONE);
        taken   = 1'b0;
        if (resolve) begin
            taken = (bus.ex_kind == KIND_JAL) || (bus.ex_kind == KIND_JALR) ||
                    ((bus.ex_kind == KIND_BRANCH) && cond_true);
        end
    end

    // Redirect FSM, misalignment pulse and accepted-redirect counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pc_branch_q     <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            count_q         <= '0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (taken) begin
                        if (target[1]) begin
                            misalign_q      <= 1'b1;
                            misalign_addr_q <= target;
                        end else begin
                            pc_branch_q <= target;
                            state       <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (bus.fetch_accept) begin
                        state   <= IDLE;
                        count_q <= count_q + 64'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.branch_taken   = (state == PENDING);
    assign bus.flush_front    = (state == PENDING);
    assign bus.pc_branch      = (state == PENDING) ? pc_branch_q : 64'd0;
    assign bus.misalign_exc   = misalign_q;
    assign bus.misalign_addr  = misalign_q ? misalign_addr_q : 64'd0;
    assign bus.redirect_count = count_q;
    assign bus.link_value     = bus.ex_pc + 64'd4;
endmodule

// File: tb/tb_branch_redirect.sv
// Self-checking bench for branch_redirect: a table of single-instruction
// resolutions checked through an expected-result queue, followed by
// hand-written multi-cycle sequences (stalled accept, reset mid-redirect).
module tb_branch_redirect;
    logic clk;
    logic reset;

    branch_redirect_if bus ();

    branch_redirect dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  funct3;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        exp_redirect;
        logic        exp_misalign;
        logic [63:0] exp_target;
    } vec_t;

    vec_t vecs [15];
    vec_t exp_q [$];

    int total;
    int bad;
    logic [63:0] exp_count;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".branch_taken"}, {63'd0, bus.branch_taken}, 64'd0);
        check({tag, ".flush_front"}, {63'd0, bus.flush_front}, 64'd0);
        check({tag, ".pc_branch"}, bus.pc_branch, 64'd0);
        check({tag, ".misalign_exc"}, {63'd0, bus.misalign_exc}, 64'd0);
        check({tag, ".redirect_count"}, bus.redirect_count, exp_count);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.ex_valid     = 1'b1;
        bus.ex_kind      = v.kind;
        bus.ex_funct3    = v.funct3;
        bus.ex_pc        = v.pc;
        bus.ex_imm       = v.imm;
        bus.ex_rs1       = v.rs1;
        bus.ex_rs2       = v.rs2;
        bus.fetch_accept = 1'b1;
        exp_q.push_back(v);
        #1;
        check("link_value", bus.link_value, v.pc + 64'd4);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            check("branch_taken", {63'd0, bus.branch_taken}, {63'd0, e.exp_redirect});
            check("flush_front", {63'd0, bus.flush_front}, {63'd0, e.exp_redirect});
            check("pc_branch", bus.pc_branch, e.exp_redirect ? e.exp_target : 64'd0);
            check("misalign_exc", {63'd0, bus.misalign_exc}, {63'd0, e.exp_misalign});
            check("misalign_addr", bus.misalign_addr, e.exp_misalign ? e.exp_target : 64'd0);
            if (e.exp_redirect) exp_count++;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_count = 64'd0;

        // kind, funct3, pc, imm, rs1, rs2, redirect, misalign, target
        vecs[0]  = '{2'd1, 3'b000, 64'h8000_0000, 64'h40, 64'd5, 64'd5, 1'b1, 1'b0, 64'h8000_0040};
        vecs[1]  = '{2'd1, 3'b000, 64'h8000_0000, 64'h40, 64'd5, 64'd6, 1'b0, 1'b0, 64'h0};
        vecs[2]  = '{2'd1, 3'b100, 64'h1000, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'h1020};
        vecs[3]  = '{2'd1, 3'b110, 64'h1000, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0};
        vecs[4]  = '{2'd3, 3'b000, 64'h7000, 64'h0, 64'h8000_1003, 64'd0, 1'b0, 1'b1, 64'h8000_1002};
        vecs[5]  = '{2'd3, 3'b000, 64'h7000, 64'h0, 64'h8000_1001, 64'd0, 1'b1, 1'b0, 64'h8000_1000};
        vecs[6]  = '{2'd1, 3'b001, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8, 64'd1, 64'd2, 1'b1, 1'b0, 64'h1FF8};
        vecs[7]  = '{2'd1, 3'b101, 64'h3000, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0};
        vecs[8]  = '{2'd1, 3'b111, 64'h3000, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'h3100};
        vecs[9]  = '{2'd1, 3'b010, 64'h3000, 64'h100, 64'd7, 64'd7, 1'b0, 1'b0, 64'h0};
        vecs[10] = '{2'd2, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd0, 64'd0, 1'b1, 1'b0, 64'h10};
        vecs[11] = '{2'd0, 3'b000, 64'h5000, 64'h40, 64'd3, 64'd3, 1'b0, 1'b0, 64'h0};
        vecs[12] = '{2'd2, 3'b000, 64'h4000, 64'h6, 64'd0, 64'd0, 1'b0, 1'b1, 64'h4006};
        vecs[13] = '{2'd3, 3'b000, 64'h6000, 64'hFFFF_FFFF_FFFF_FFFD, 64'h5000, 64'd0, 1'b1, 1'b0, 64'h4FFC};
        vecs[14] = '{2'd1, 3'b100, 64'h100, 64'h10, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 64'h0};

        bus.ex_valid     = 1'b0;
        bus.ex_kind      = 2'd0;
        bus.ex_funct3    = 3'd0;
        bus.ex_pc        = 64'd0;
        bus.ex_imm       = 64'd0;
        bus.ex_rs1       = 64'd0;
        bus.ex_rs2       = 64'd0;
        bus.fetch_accept = 1'b0;

        // Reset held for two cycles, then idle with ex_valid low
        reset = 1'b1;
        tick();
        tick();
        checkIdle("reset_held");
        check("reset.misalign_addr", bus.misalign_addr, 64'd0);
        check("reset.link_value", bus.link_value, 64'd4);
        reset = 1'b0;
        tick();
        checkIdle("after_reset");
        tick();
        checkIdle("idle_no_valid");

        // Table: each vector resolves with fetch_accept high, so any redirect is a one-cycle pulse
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            tick();
            bus.ex_valid = 1'b0;
            checkOutput();
            tick();
            checkIdle("vec_after");
        end

        // Stalled accept: JAL held pending for four cycles while a taken BNE sits in EX
        bus.ex_valid     = 1'b1;
        bus.ex_kind      = 2'd2;
        bus.ex_pc        = 64'h100;
        bus.ex_imm       = 64'h80;
        bus.fetch_accept = 1'b0;
        tick();
        bus.ex_kind   = 2'd1;
        bus.ex_funct3 = 3'b001;
        bus.ex_pc     = 64'h900;
        bus.ex_imm    = 64'h10;
        bus.ex_rs1    = 64'd1;
        bus.ex_rs2    = 64'd2;
        for (int c = 0; c < 4; c++) begin
            check("stall.branch_taken", {63'd0, bus.branch_taken}, 64'd1);
            check("stall.flush_front", {63'd0, bus.flush_front}, 64'd1);
            check("stall.pc_branch", bus.pc_branch, 64'h180);
            check("stall.redirect_count", bus.redirect_count, exp_count);
            if (c == 3) bus.fetch_accept = 1'b1;
            tick();
        end
        exp_count++;
        bus.ex_valid = 1'b0;
        checkIdle("stall_accepted");
        tick();
        checkIdle("stall_no_replay");

        // Reset while a redirect is pending drops it and clears the counter
        bus.ex_valid     = 1'b1;
        bus.ex_kind      = 2'd2;
        bus.ex_pc        = 64'h200;
        bus.ex_imm       = 64'h40;
        bus.fetch_accept = 1'b0;
        tick();
        bus.ex_valid = 1'b0;
        check("rstpend.branch_taken", {63'd0, bus.branch_taken}, 64'd1);
        check("rstpend.pc_branch", bus.pc_branch, 64'h240);
        reset = 1'b1;
        tick();
        exp_count = 64'd0;
        checkIdle("rstpend_reset");
        reset = 1'b0;
        tick();
        checkIdle("rstpend_no_replay");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
